wave_sequencer: RTL and testbench
=================================

Name: wave_sequencer

Overview:
Controller that drives the 3-bit waveform-select input of the lab waveform generator, replacing raw slide switches.
- Steps the selection automatically after a programmable dwell time, or manually on a push-button edge; direction is up or down.
- Optionally defers each change until the generator reports a period boundary, so no partial waveform period is emitted at a switch.
- Sits between board I/O (KEY/SW) and the generator's select port.

Parameters:
SEL_W, 3, width of waveform select; sequence wraps modulo 2^SEL_W
DWELL, 7500, auto-mode cycles per selection (150 us at 50 MHz)
TIMEOUT, 1024, max cycles to wait for wrap before a forced switch
SYNC_SWITCH, 1, 1 = defer change to wrap pulse; 0 = change immediately

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  sequencer enable; 0 freezes sel_out and drops pending requests
mode  in  1  0 = manual (button), 1 = auto (dwell timer)
dir  in  1  0 = increment select, 1 = decrement
step_btn  in  1  raw asynchronous push-button, active-high
wrap  in  1  one-cycle pulse from generator at start of a wave period
sel_out  out  SEL_W  waveform select to generator
switch_pulse  out  1  one-cycle pulse in the cycle sel_out changes
pending  out  1  high while a switch waits for wrap
forced  out  1  one-cycle pulse when a switch was forced by timeout

Behaviour:
- Reset (async, immediate): sel_out=0, switch_pulse=0, pending=0, forced=0, state=IDLE, dwell/timeout counters=0, synchronizer flops=0.
- step_btn: 2-flop synchronizer plus rising-edge detect gives step_req, one cycle wide.
  - Latency: 3 clk edges from step_btn rise to step_req high.
  - A held button yields exactly one step_req.
- States: IDLE, RUN, PEND.
- IDLE: entered at reset and whenever en=0 (from any state).
  - Counters cleared; pending request discarded; sel_out held.
  - Moves to RUN on the first cycle en=1.
- RUN:
  - auto (mode=1): dwell_cnt increments each cycle. At DWELL-1 a request is raised and dwell_cnt returns to 0.
  - auto, step_req: raises a request immediately and clears dwell_cnt.
  - manual (mode=0): dwell_cnt held at 0; only step_req raises a request.
  - Request handling: next_sel = sel_out+1 (dir=0) or sel_out-1 (dir=1), modulo 2^SEL_W. Wraps 7->0 up, 0->7 down. dir is sampled in the request cycle.
  - SYNC_SWITCH=0: sel_out<=next_sel and switch_pulse=1 on the clock edge ending the request cycle; stay in RUN.
  - SYNC_SWITCH=1: latch next_sel, go to PEND, pending=1 from the next cycle. A wrap in the request cycle itself is ignored.
- PEND:
  - dwell_cnt frozen; timeout_cnt increments each cycle.
  - Further requests (step_req or dwell expiry) are dropped; at most one pending switch exists.
  - wrap=1: sel_out<=latched next_sel, switch_pulse=1, pending=0, timeout_cnt=0, then RUN.
  - timeout_cnt reaches TIMEOUT-1 without wrap: same update, plus forced=1 for that cycle.
  - wrap and timeout in the same cycle: treated as wrap; forced=0.
  - en=0: go to IDLE, drop the switch, sel_out unchanged, pending=0.
- Mode change RUN auto->manual clears dwell_cnt. manual->auto starts dwell from 0.
- Outputs are registered; sel_out never glitches and changes only together with switch_pulse.

Decomposition:
- Package wave_seq_pkg holds:
  - state enum {IDLE, RUN, PEND};
  - SEL_W default constant;
  - helper function next_sel(sel, dir).
- One sub-module: btn_sync_edge, the 2-flop synchronizer plus rising-edge detector producing step_req.

Test Plan:
- Reset check: assert rst mid-run with sel_out=5 -> sel_out=0 and pending=0 immediately, before any clk edge.
- Auto stepping (DWELL=8, SYNC_SWITCH=0, dir=0, en=1): sel_out goes 0,1,...,7,0, switch_pulse every 8 cycles, wrap 7->0 verified.
- Manual step (mode=0, dir=1, SYNC_SWITCH=0, start sel=0): button held 20 cycles -> exactly one switch_pulse, sel_out=7, 3-4 cycles after press.
- Sync switch (SYNC_SWITCH=1): step_req, then wrap 10 cycles later.
  - pending high during the wait; sel_out changes only with wrap; forced=0.
  - A second press while pending is dropped, leaving a net change of +1.
- Timeout (TIMEOUT=16): request with no wrap -> at 16 cycles sel_out advances, switch_pulse=1, forced=1. Repeat with wrap in the timeout cycle -> forced=0.
- Disable in PEND: en=0 while pending -> IDLE, pending=0, sel_out unchanged. Later wrap -> no change. en=1 -> auto dwell restarts from 0.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and helpers for the waveform-select sequencer.
package wave_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

    localparam int unsigned SEL_W_DEFAULT = 3;

    // Step a select value up (dir=0) or down (dir=1), wrapping modulo 2^width.
    function automatic logic [31:0] next_sel(input logic [31:0] sel, input logic dir,
                                             input int unsigned width);
        logic [31:0] mask;
        logic [31:0] res;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        res  = dir ? (sel - 32'd1) : (sel + 32'd1);
        return res & mask;
    endfunction

endpackage

// File: rtl/wave_sequencer_btn_sync_edge.sv
// Two-flop synchronizer for the raw step button plus a registered rising-edge detect.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic step_req_o
);

    // [0],[1] synchronizer stages, [2] previous synchronized level
    logic [2:0] sync_q, sync_d;
    logic       req_q, req_d;

    always_comb begin
        sync_d = {sync_q[1:0], btn_i};
        req_d  = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            req_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            req_q  <= req_d;
        end
    end

    assign step_req_o = req_q;

endmodule

// File: rtl/wave_sequencer.sv
// Steps the generator's waveform select on a dwell timer or button press, optionally
// deferring each change to the generator's period-boundary pulse.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int unsigned SEL_W       = SEL_W_DEFAULT,
    parameter int unsigned DWELL       = 7500,
    parameter int unsigned TIMEOUT     = 1024,
    parameter bit          SYNC_SWITCH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             step_btn,
    input  logic             wrap,
    output logic [SEL_W-1:0] sel_out,
    output logic             switch_pulse,
    output logic             pending,
    output logic             forced
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] nxt_q, nxt_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             switch_q, switch_d;
    logic             forced_q, forced_d;
    logic             step_req;
    logic             req;
    logic [31:0]      nsel_w;
    logic [SEL_W-1:0] nsel;
    logic             unused_nsel_hi;

    btn_sync_edge u_btn (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_i      (step_btn),
        .step_req_o (step_req)
    );

    assign nsel_w         = next_sel(32'(sel_q), dir, SEL_W);
    assign nsel           = nsel_w[SEL_W-1:0];
    assign unused_nsel_hi = ^nsel_w[31:SEL_W];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        nxt_d    = nxt_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        switch_d = 1'b0;
        forced_d = 1'b0;
        req      = 1'b0;

        if (!en) begin
            // Disable overrides every state and discards any deferred switch.
            state_d = IDLE;
            dwell_d = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dwell_d = '0;
                    tmo_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    if (mode) begin
                        if (step_req || dwell_q == DwellLast) begin
                            req     = 1'b1;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end else begin
                        dwell_d = '0;
                        req     = step_req;
                    end
                    if (req) begin
                        if (SYNC_SWITCH) begin
                            nxt_d   = nsel;
                            tmo_d   = '0;
                            state_d = PEND;
                        end else begin
                            sel_d    = nsel;
                            switch_d = 1'b1;
                        end
                    end
                end
                PEND: begin
                    // Wrap wins over a coincident timeout, so forced stays low then.
                    if (wrap || tmo_q == TmoLast) begin
                        sel_d    = nxt_q;
                        switch_d = 1'b1;
                        forced_d = ~wrap;
                        tmo_d    = '0;
                        state_d  = RUN;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            nxt_q    <= '0;
            dwell_q  <= '0;
            tmo_q    <= '0;
            switch_q <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            nxt_q    <= nxt_d;
            dwell_q  <= dwell_d;
            tmo_q    <= tmo_d;
            switch_q <= switch_d;
            forced_q <= forced_d;
        end
    end

    assign sel_out      = sel_q;
    assign switch_pulse = switch_q;
    assign forced       = forced_q;
    assign pending      = (state_q == PEND);

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench: one immediate-switch and one wrap-synchronized sequencer on shared inputs.
module tb_wave_sequencer;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DWELL   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, mode = 1'b0, dir = 1'b0, step_btn = 1'b0, wrap = 1'b0;

    logic [SEL_W-1:0] a_sel, s_sel;
    logic a_pulse, a_pend, a_forced;
    logic s_pulse, s_pend, s_forced;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             forced;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wave_sequencer #(
        .SEL_W(SEL_W), .DWELL(DWELL), .TIMEOUT(TIMEOUT), .SYNC_SWITCH(1'b0)
    ) u_imm (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step_btn(step_btn),
        .wrap(wrap), .sel_out(a_sel), .switch_pulse(a_pulse), .pending(a_pend),
        .forced(a_forced)
    );

    wave_sequencer #(
        .SEL_W(SEL_W), .DWELL(DWELL), .TIMEOUT(TIMEOUT), .SYNC_SWITCH(1'b1)
    ) u_sync (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step_btn(step_btn),
        .wrap(wrap), .sel_out(s_sel), .switch_pulse(s_pulse), .pending(s_pend),
        .forced(s_forced)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; step_btn = 1'b0; wrap = 1'b0;
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bit hit;
        do_reset();
        n_checks++;
        if (a_sel !== 3'd0 || a_pend !== 1'b0 || a_pulse !== 1'b0 || a_forced !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_imm: sel=%0d pend=%b pulse=%b forced=%b, want 0 0 0 0",
                     a_sel, a_pend, a_pulse, a_forced);
        end
        n_checks++;
        if (s_sel !== 3'd0 || s_pend !== 1'b0 || s_pulse !== 1'b0 || s_forced !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sync: sel=%0d pend=%b pulse=%b forced=%b, want 0 0 0 0",
                     s_sel, s_pend, s_pulse, s_forced);
        end
        en = 1'b1; mode = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (a_sel === 3'd5) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_reach5: sel=%0d, want 5 within 100 cycles", a_sel);
        end
        // Drive reset mid-cycle and look before the next rising edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (a_sel !== 3'd0 || a_pend !== 1'b0 || s_sel !== 3'd0 || s_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: imm sel=%0d pend=%b sync sel=%0d pend=%b, want all 0",
                     a_sel, a_pend, s_sel, s_pend);
        end
        tick();
    endtask

    task automatic test_auto();
        exp_t e;
        int   last, pulses, glitches;
        logic [SEL_W-1:0] prev;
        do_reset();
        for (int v = 1; v <= 8; v++) begin
            e.sel = SEL_W'(v);
            e.forced = 1'b0;
            sb_q.push_back(e);
        end
        en = 1'b1; mode = 1'b1; dir = 1'b0;
        last = -1; pulses = 0; glitches = 0; prev = a_sel;
        for (int cyc = 0; cyc < 120 && pulses < 8; cyc++) begin
            tick();
            if (a_sel !== prev && !a_pulse) glitches++;
            prev = a_sel;
            if (a_pulse) begin
                pulses++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL auto_extra_pulse: sel=%0d, want no pulse", a_sel);
                end else begin
                    e = sb_q.pop_front();
                    if (a_sel !== e.sel || a_forced !== e.forced) begin
                        n_fail++;
                        $display("FAIL auto_step: sel=%0d forced=%b, want %0d %b",
                                 a_sel, a_forced, e.sel, e.forced);
                    end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 8) begin
                        n_fail++;
                        $display("FAIL auto_interval: %0d cycles, want 8", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_checks++;
        if (sb_q.size() != 0 || a_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL auto_wrap: left=%0d sel=%0d, want 0 left and sel 0",
                     sb_q.size(), a_sel);
        end
        n_checks++;
        if (glitches != 0) begin
            n_fail++;
            $display("FAIL auto_no_pulse_change: %0d changes without pulse, want 0", glitches);
        end
    endtask

    task automatic test_manual();
        exp_t e;
        int   pulses;
        do_reset();
        en = 1'b1; mode = 1'b0; dir = 1'b1;
        tick();
        tick();
        e.sel = 3'd7;
        e.forced = 1'b0;
        sb_q.push_back(e);
        pulses = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_pulse) begin
                pulses++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL manual_extra_pulse: cycle %0d sel=%0d, want none", i, a_sel);
                end else begin
                    e = sb_q.pop_front();
                    if (a_sel !== e.sel || i < 3 || i > 4) begin
                        n_fail++;
                        $display("FAIL manual_step: sel=%0d at cycle %0d, want %0d at 3..4",
                                 a_sel, i, e.sel);
                    end
                end
            end
        end
        step_btn = 1'b0;
        n_checks++;
        if (pulses != 1 || a_sel !== 3'd7) begin
            n_fail++;
            $display("FAIL manual_once: pulses=%0d sel=%0d, want 1 and 7", pulses, a_sel);
        end
    endtask

    task automatic test_sync_switch();
        exp_t e;
        int   pulses;
        do_reset();
        en = 1'b1; mode = 1'b0; dir = 1'b0;
        tick();
        e.sel = 3'd1;
        e.forced = 1'b0;
        sb_q.push_back(e);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            // First press, then a second press while the switch is still deferred.
            step_btn = (i < 3) || (i >= 7 && i < 9);
            wrap = (i == 14);
            tick();
            if (i >= 3 && i <= 13) begin
                n_checks++;
                if (s_pend !== 1'b1 || s_sel !== 3'd0 || s_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sync_wait: i=%0d pend=%b sel=%0d pulse=%b, want 1 0 0",
                             i, s_pend, s_sel, s_pulse);
                end
            end
            if (s_pulse) begin
                pulses++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sync_extra_pulse: i=%0d sel=%0d, want none", i, s_sel);
                end else begin
                    e = sb_q.pop_front();
                    if (s_sel !== e.sel || s_forced !== e.forced || i != 14) begin
                        n_fail++;
                        $display("FAIL sync_step: sel=%0d forced=%b i=%0d, want %0d %b 14",
                                 s_sel, s_forced, i, e.sel, e.forced);
                    end
                end
            end
        end
        wrap = 1'b0;
        step_btn = 1'b0;
        n_checks++;
        if (pulses != 1 || s_sel !== 3'd1 || s_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_net: pulses=%0d sel=%0d pend=%b, want 1 1 0",
                     pulses, s_sel, s_pend);
        end
    endtask

    task automatic run_pend(input int wrap_at, input logic [SEL_W-1:0] exp_sel,
                            input logic exp_forced);
        exp_t e;
        int   cnt;
        bit   seen;
        e.sel = exp_sel;
        e.forced = exp_forced;
        sb_q.push_back(e);
        step_btn = 1'b1;
        tick();
        tick();
        tick();
        step_btn = 1'b0;
        for (int i = 0; i < 10 && !s_pend; i++) tick();
        n_checks++;
        if (!s_pend) begin
            n_fail++;
            $display("FAIL tmo_no_pending: pend=%b, want 1", s_pend);
        end
        seen = 1'b0;
        cnt = 0;
        while (cnt < 30 && !seen) begin
            wrap = (cnt == wrap_at);
            tick();
            wrap = 1'b0;
            cnt++;
            if (s_pulse) begin
                seen = 1'b1;
                n_checks++;
                e = sb_q.pop_front();
                if (s_sel !== e.sel || s_forced !== e.forced || cnt != 16 || s_pend !== 1'b0)
                begin
                    n_fail++;
                    $display("FAIL tmo_step: sel=%0d forced=%b after %0d pend=%b, want %0d %b 16 0",
                             s_sel, s_forced, cnt, s_pend, e.sel, e.forced);
                end
                tick();
                n_checks++;
                if (s_forced !== 1'b0 || s_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_one_cycle: forced=%b pulse=%b, want 0 0",
                             s_forced, s_pulse);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL tmo_missing: no switch after %0d cycles, want one at 16", cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        en = 1'b1; mode = 1'b0; dir = 1'b0;
        tick();
        run_pend(-1, 3'd1, 1'b1);
        tick();
        tick();
        run_pend(15, 3'd2, 1'b0);
    endtask

    task automatic test_disable();
        exp_t e;
        int   cnt;
        do_reset();
        en = 1'b1; mode = 1'b1; dir = 1'b0;
        for (int i = 0; i < 20 && !s_pend; i++) tick();
        n_checks++;
        if (!s_pend) begin
            n_fail++;
            $display("FAIL dis_no_pending: pend=%b, want 1", s_pend);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (s_pend !== 1'b0 || s_sel !== 3'd0 || s_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_idle: pend=%b sel=%0d pulse=%b, want 0 0 0",
                     s_pend, s_sel, s_pulse);
        end
        wrap = 1'b1;
        tick();
        wrap = 1'b0;
        tick();
        n_checks++;
        if (s_sel !== 3'd0 || s_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_wrap_ignored: sel=%0d pulse=%b, want 0 0", s_sel, s_pulse);
        end
        en = 1'b1;
        cnt = 0;
        while (cnt < 20 && !s_pend) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 9) begin
            n_fail++;
            $display("FAIL dis_dwell_restart: pending after %0d cycles, want 9", cnt);
        end
        e.sel = 3'd1;
        e.forced = 1'b0;
        sb_q.push_back(e);
        wrap = 1'b1;
        tick();
        wrap = 1'b0;
        n_checks++;
        if (!s_pulse) begin
            n_fail++;
            $display("FAIL dis_resume: pulse=%b, want 1", s_pulse);
        end else begin
            e = sb_q.pop_front();
            if (s_sel !== e.sel || s_forced !== e.forced) begin
                n_fail++;
                $display("FAIL dis_resume: sel=%0d forced=%b, want %0d %b",
                         s_sel, s_forced, e.sel, e.forced);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_auto();
        test_manual();
        test_sync_switch();
        test_timeout();
        test_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
